smg_scanmux_mod: RTL and testbench
==================================

# smg_scanmux_mod

Parametrised multiplexed seven-segment display controller: the next generation of the team's fixed 6-digit scanner. It drives DIGITS common-select digits from a packed hex word with per-digit decimal points, optional leading-zero suppression and PWM brightness. Display data is double-buffered, so updates take effect only at frame boundaries and never tear. It sits between any data-producing module and the board's DIG/SEL pins.

## Interface
- DIGITS, 6: number of digits (1..16)
- CLK_HZ, 50_000_000: CLOCK frequency in Hz
- SCAN_US, 1000: nominal dwell per digit in µs
- BRIGHT_W, 4: brightness resolution in bits
- SEG_ACTIVE_LOW, 1: 1 = DIG pins active-low
- SEL_ACTIVE_LOW, 1: 1 = SEL pins active-low
- CLOCK  in  1  system clock; all logic on rising edge
- RESET  in  1  asynchronous, active-low reset
- iData  in  4*DIGITS  hex nibbles; nibble k = iData[4k+3:4k] drives digit k (digit 0 = rightmost)
- iDot  in  DIGITS  decimal point per digit
- iBright  in  BRIGHT_W  brightness code
- iBlankLZ  in  1  leading-zero suppression enable
- iLoad  in  1  one-cycle strobe: capture iData/iDot/iBright/iBlankLZ into staging
- DIG  out  8  segments; DIG[7]=dp, DIG[6:0]=g..a
- SEL  out  DIGITS  digit select, one-hot when lit
- oFrame  out  1  one-cycle pulse at each frame boundary
- oPending  out  1  staging holds data not yet displayed

## Operation
- SLOT = (CLK_HZ/1_000_000*SCAN_US) >> BRIGHT_W cycles; SLOT >= 1 is an elaboration error otherwise. Dwell = SLOT << BRIGHT_W cycles.
- Counters: prescaler 0..SLOT-1; slot index 0..2^BRIGHT_W-1 (advances on prescaler wrap); digit index 0..DIGITS-1 (advances on slot wrap, wraps DIGITS-1 -> 0).
- Frame boundary: edge where digit index wraps DIGITS-1 -> 0. On it: oFrame=1; if oPending, shadow <= staging, oPending <= 0.
- iLoad: staging <= inputs, oPending <= 1; latest strobe wins. iLoad on a boundary edge bypasses staging: shadow <= inputs directly, oPending <= 0.
- Brightness (shadow value B): digit lit while slot index <= B; dark otherwise. B = 0 → 1/2^BRIGHT_W duty; B = max → full duty.
- Per-digit state machine: LIT -> DARK when slot index passes B; DARK -> LIT at next digit start. With B = max, DARK is never entered.
- Lit: SEL one-hot on current digit; DIG = encode(nibble) plus dp. Dark: SEL and DIG all inactive.
- Encoding (active-high, before polarity): 0→3F 1→06 2→5B 3→4F 4→66 5→6D 6→7D 7→07 8→7F 9→6F A→77 b→7C C→39 d→5E E→79 F→71.
- Leading-zero suppression (shadow flag set): digits from DIGITS-1 downward whose nibbles are 0 up to the first nonzero nibble have segments a–g blank. Digit 0 is never suppressed. Dp is still shown on suppressed digits. SEL still asserts.
- Polarity params invert DIG/SEL at the output register only.

## Timing
- Reset: all counters 0, shadow and staging 0, B = 0, oPending 0, oFrame 0, DIG/SEL inactive (all 1s when active-low).
- First edge after RESET release: digit 0, slot 0. DIG/SEL are registered and reflect that state one cycle later.
- Display latency: state change → pins 1 cycle.
- iLoad → shadow: at the next boundary, or the same edge if on a boundary.
- Reset mid-frame: immediate return to the reset state. Pending data is discarded.

## Structure
- Package smg_pkg: 16-entry segment constant table, SEG_DP bit index, localparam helpers for SLOT.
- Sub-module smg_hexseg_encode: combinational 4-bit → 7-segment encoder, active-high.
- Rest is one module: counters, double buffer, LZ mask, output registers.

## Test plan
All scenarios use CLK_HZ=1_000_000, SCAN_US=16, BRIGHT_W=2, DIGITS=4 (SLOT=4, dwell 16, frame 64), active-low.
- Reset: hold RESET low 5 cycles → DIG=FF, SEL=F, oFrame=0, oPending=0. Release → SEL=E after 1 cycle.
- Load 0x12A0, dots 0001, B=3, then wait for boundary → digit 0 shows DIG=~(3F|80)=40 for 16 cycles. Digit 1 shows ~77=88. Digit 3 shows ~06=F9. oFrame every 64 cycles.
- B=0 → each digit lit 4 of 16 cycles, dark 12. B=2 → lit 12 of 16.
- Load 0x0005 with iBlankLZ=1, dots 0100 → digits 3 and 1 show DIG=FF. Digit 2 shows DIG=7F. Digit 0 shows ~6D=92.
- Two iLoad strobes mid-frame (0x1111 then 0x2222) → frame unchanged, oPending=1. After boundary, 0x2222 is shown and oPending=0. An iLoad exactly on the boundary edge is displayed in the starting frame.
- Assert RESET mid-digit with oPending=1 → outputs inactive immediately, oPending=0. After release, display shows 0000 (shadow cleared).

Source files
------------

// File: rtl/smg_pkg.sv
// Shared constants and elaboration helpers for the multiplexed seven-segment scanner.
package smg_pkg;

  // Bit index of the decimal point within the 8-bit segment bus.
  localparam int unsigned SEG_DP = 7;

  // Active-high g..a patterns for hex digits 0..F.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [0:0] {
    StLit,
    StDark
  } lit_state_e;

  // Cycles per brightness slot; the full digit dwell is this value shifted up by bright_w.
  function automatic int unsigned slot_cycles(input int unsigned clk_hz,
                                              input int unsigned scan_us,
                                              input int unsigned bright_w);
    longint unsigned dwell;
    dwell = (longint'(clk_hz) / 64'd1_000_000) * longint'(scan_us);
    return int'(dwell >> bright_w);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/smg_scanmux_mod_if.sv
// Data-producer to display-controller bundle: staged display inputs plus the pin-side outputs.
interface smg_scanmux_mod_if #(
  parameter int unsigned DIGITS   = 6,
  parameter int unsigned BRIGHT_W = 4
);
  logic [4*DIGITS-1:0] iData;
  logic [DIGITS-1:0]   iDot;
  logic [BRIGHT_W-1:0] iBright;
  logic                iBlankLZ;
  logic                iLoad;
  logic [7:0]          DIG;
  logic [DIGITS-1:0]   SEL;
  logic                oFrame;
  logic                oPending;

  modport master (
    output iData, iDot, iBright, iBlankLZ, iLoad,
    input  DIG, SEL, oFrame, oPending
  );

  modport slave (
    input  iData, iDot, iBright, iBlankLZ, iLoad,
    output DIG, SEL, oFrame, oPending
  );
endinterface

// File: rtl/smg_hexseg_encode.sv
// Combinational hex nibble to active-high seven-segment (g..a) encoder.
module smg_hexseg_encode
  import smg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/smg_scanmux_mod.sv
// Multiplexed seven-segment scanner: double-buffered digits, PWM brightness via slot counting,
// optional leading-zero blanking, registered polarity-adjusted DIG/SEL outputs.
module smg_scanmux_mod
  import smg_pkg::*;
#(
  parameter int unsigned DIGITS         = 6,
  parameter int unsigned CLK_HZ         = 50_000_000,
  parameter int unsigned SCAN_US        = 1000,
  parameter int unsigned BRIGHT_W       = 4,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input logic               CLOCK,
  input logic               RESET,
  smg_scanmux_mod_if.slave  bus
);

  localparam int unsigned SLOT = slot_cycles(CLK_HZ, SCAN_US, BRIGHT_W);
  localparam int unsigned PW   = cnt_width(SLOT);
  localparam int unsigned DW   = cnt_width(DIGITS);

  if (SLOT < 1 || DIGITS < 1 || DIGITS > 16) begin : g_bad_cfg
    $error("smg_scanmux_mod: slot length below one cycle or DIGITS outside 1..16");
  end

  localparam logic [PW-1:0]       PRESC_LAST = PW'(SLOT - 1);
  localparam logic [BRIGHT_W-1:0] SLOT_LAST  = '1;
  localparam logic [DW-1:0]       DIGIT_LAST = DW'(DIGITS - 1);
  localparam logic [7:0]          DIG_OFF    = {8{SEG_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0]   SEL_OFF    = {DIGITS{SEL_ACTIVE_LOW}};

  logic [PW-1:0]       presc_q, presc_d;
  logic [BRIGHT_W-1:0] slot_q, slot_d;
  logic [DW-1:0]       digit_q, digit_d;
  lit_state_e          state_q, state_d;

  logic [DIGITS-1:0][3:0] shd_data_q, stg_data_q;
  logic [DIGITS-1:0]      shd_dot_q, stg_dot_q;
  logic [BRIGHT_W-1:0]    shd_bright_q, stg_bright_q;
  logic                   shd_blank_q, stg_blank_q;
  logic                   pending_q;
  logic                   frame_q;
  logic [7:0]             dig_q, dig_d;
  logic [DIGITS-1:0]      sel_q, sel_d;

  logic [DIGITS-1:0][3:0] in_data;
  logic                   presc_wrap, slot_wrap, boundary;
  logic [DIGITS-1:0]      suppress;
  logic                   zero_run;
  logic [6:0]             cur_seg;
  logic [7:0]             lit_dig;
  logic [DIGITS-1:0]      sel_hot;

  assign in_data    = bus.iData;
  assign presc_wrap = (presc_q == PRESC_LAST);
  assign slot_wrap  = presc_wrap && (slot_q == SLOT_LAST);
  assign boundary   = slot_wrap && (digit_q == DIGIT_LAST);

  // Scan counters and per-digit lit/dark machine.
  always_comb begin
    presc_d = presc_q + 1'b1;
    slot_d  = slot_q;
    digit_d = digit_q;
    state_d = state_q;
    if (presc_wrap) begin
      presc_d = '0;
      slot_d  = slot_q + 1'b1;
      if (slot_q == SLOT_LAST) begin
        digit_d = (digit_q == DIGIT_LAST) ? '0 : digit_q + 1'b1;
      end
    end
    unique case (state_q)
      StLit: begin
        if (presc_wrap && (slot_q != SLOT_LAST) && (slot_d > shd_bright_q)) begin
          state_d = StDark;
        end
      end
      StDark: begin
        if (slot_wrap) begin
          state_d = StLit;
        end
      end
      default: state_d = StLit;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      presc_q <= '0;
      slot_q  <= '0;
      digit_q <= '0;
      state_q <= StLit;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
      digit_q <= digit_d;
      state_q <= state_d;
    end
  end

  // Double buffer: a strobe landing on the boundary edge goes straight to the shadow.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      shd_data_q   <= '0;
      shd_dot_q    <= '0;
      shd_bright_q <= '0;
      shd_blank_q  <= 1'b0;
      stg_data_q   <= '0;
      stg_dot_q    <= '0;
      stg_bright_q <= '0;
      stg_blank_q  <= 1'b0;
      pending_q    <= 1'b0;
    end else if (bus.iLoad) begin
      if (boundary) begin
        shd_data_q   <= in_data;
        shd_dot_q    <= bus.iDot;
        shd_bright_q <= bus.iBright;
        shd_blank_q  <= bus.iBlankLZ;
        pending_q    <= 1'b0;
      end else begin
        stg_data_q   <= in_data;
        stg_dot_q    <= bus.iDot;
        stg_bright_q <= bus.iBright;
        stg_blank_q  <= bus.iBlankLZ;
        pending_q    <= 1'b1;
      end
    end else if (boundary && pending_q) begin
      shd_data_q   <= stg_data_q;
      shd_dot_q    <= stg_dot_q;
      shd_bright_q <= stg_bright_q;
      shd_blank_q  <= stg_blank_q;
      pending_q    <= 1'b0;
    end
  end

  // A digit is suppressed while it and every digit above it hold zero; digit 0 never is.
  always_comb begin
    zero_run = shd_blank_q;
    suppress = '0;
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      zero_run    = zero_run && (shd_data_q[k] == 4'h0);
      suppress[k] = zero_run;
    end
  end

  smg_hexseg_encode u_encode (
    .nib_i (shd_data_q[digit_q]),
    .seg_o (cur_seg)
  );

  always_comb begin
    lit_dig         = {1'b0, (suppress[digit_q] ? 7'h00 : cur_seg)};
    lit_dig[SEG_DP] = shd_dot_q[digit_q];
    sel_hot          = '0;
    sel_hot[digit_q] = 1'b1;
    dig_d = '0;
    sel_d = '0;
    if (state_q == StLit) begin
      dig_d = lit_dig;
      sel_d = sel_hot;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      dig_q   <= DIG_OFF;
      sel_q   <= SEL_OFF;
      frame_q <= 1'b0;
    end else begin
      dig_q   <= dig_d ^ DIG_OFF;
      sel_q   <= sel_d ^ SEL_OFF;
      frame_q <= boundary;
    end
  end

  assign bus.DIG      = dig_q;
  assign bus.SEL      = sel_q;
  assign bus.oFrame   = frame_q;
  assign bus.oPending = pending_q;

endmodule

// File: tb/tb_smg_scanmux_mod.sv
// Scoreboard bench for smg_scanmux_mod: a time-indexed display model predicts every pin cycle.
module tb_smg_scanmux_mod;

  logic CLOCK;
  logic RESET;

  smg_scanmux_mod_if #(.DIGITS(4), .BRIGHT_W(2)) bus ();

  smg_scanmux_mod #(
    .DIGITS         (4),
    .CLK_HZ         (1_000_000),
    .SCAN_US        (16),
    .BRIGHT_W       (2),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic [7:0] dig;
    logic [3:0] sel;
    logic       frame;
    logic       pend;
  } exp_t;

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t q[$];

  // Model: t counts clock edges since reset release; frame = 64 cycles, digit = 16, slot = 4.
  int unsigned t;
  logic [15:0] m_data, s_data;
  logic [3:0]  m_dot, s_dot;
  logic [1:0]  m_b, s_b;
  logic        m_blank, s_blank, m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  function automatic exp_t reset_item();
    exp_t e;
    e.dig = 8'hFF; e.sel = 4'hF; e.frame = 1'b0; e.pend = 1'b0;
    return e;
  endfunction

  function automatic exp_t show(input int unsigned tt);
    exp_t        e;
    int unsigned d, s;
    logic [6:0]  seg;
    d = (tt / 16) % 4;
    s = (tt / 4) % 4;
    e = reset_item();
    if (s <= int'(m_b)) begin
      seg = seg_tab[m_data[4*d +: 4]];
      if (m_blank && d > 0 && (m_data >> (4*d)) == 16'h0) seg = 7'h00;
      e.dig = ~{m_dot[d], seg};
      e.sel = ~(4'b0001 << d);
    end
    return e;
  endfunction

  initial begin
    exp_t e;
    logic bnd;
    t = 0; m_data = '0; s_data = '0; m_dot = '0; s_dot = '0;
    m_b = '0; s_b = '0; m_blank = 1'b0; s_blank = 1'b0; m_pend = 1'b0;
    forever begin
      @(posedge CLOCK or negedge RESET);
      if (!RESET) begin
        t = 0; m_data = '0; s_data = '0; m_dot = '0; s_dot = '0;
        m_b = '0; s_b = '0; m_blank = 1'b0; s_blank = 1'b0; m_pend = 1'b0;
        q.delete();
        q.push_back(reset_item());
      end else begin
        e   = show(t);
        bnd = ((t % 64) == 63);
        if (bus.iLoad) begin
          if (bnd) begin
            m_data = bus.iData; m_dot = bus.iDot; m_b = bus.iBright; m_blank = bus.iBlankLZ;
            m_pend = 1'b0;
          end else begin
            s_data = bus.iData; s_dot = bus.iDot; s_b = bus.iBright; s_blank = bus.iBlankLZ;
            m_pend = 1'b1;
          end
        end else if (bnd && m_pend) begin
          m_data = s_data; m_dot = s_dot; m_b = s_b; m_blank = s_blank;
          m_pend = 1'b0;
        end
        e.frame = bnd;
        e.pend  = m_pend;
        q.push_back(e);
        t++;
      end
    end
  end

  // Monitor: pins are sampled on the falling edge, half a cycle after they update.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("pins{DIG,SEL,oFrame,oPending}",
              {18'h0, bus.DIG, bus.SEL, bus.oFrame, bus.oPending},
              {18'h0, e.dig, e.sel, e.frame, e.pend});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic load(input logic [15:0] data, input logic [3:0] dot, input logic [1:0] b,
                      input logic blank);
    bus.iData = data; bus.iDot = dot; bus.iBright = b; bus.iBlankLZ = blank;
    bus.iLoad = 1'b1;
    cyc(1);
    bus.iLoad = 1'b0;
    bus.iData = 16'($urandom); bus.iDot = 4'($urandom);
    bus.iBright = 2'($urandom); bus.iBlankLZ = 1'($urandom);
  endtask

  task automatic wait_midframe();
    bit ok = 1'b0;
    cyc(1);
    for (int i = 0; i < 70 && !ok; i++) begin
      if ((t % 64) >= 4 && (t % 64) <= 20) ok = 1'b1;
      else cyc(1);
    end
    check("wait_midframe reached", 32'(ok), 32'd1);
  endtask

  task automatic load_on_boundary(input logic [15:0] data, input logic [3:0] dot,
                                  input logic [1:0] b, input logic blank);
    bit ok = 1'b0;
    cyc(1);
    for (int i = 0; i < 70 && !ok; i++) begin
      if ((t % 64) == 63) ok = 1'b1;
      else cyc(1);
    end
    check("boundary reached", 32'(ok), 32'd1);
    load(data, dot, b, blank);
  endtask

  // Wait for oFrame, then check slot 0 of each digit of the frame that follows.
  task automatic expect_frame(input string name, input logic [31:0] digs);
    bit found = 1'b0;
    for (int i = 0; i < 130 && !found; i++) begin
      @(negedge CLOCK);
      if (bus.oFrame) found = 1'b1;
    end
    check({name, " oFrame seen"}, 32'(found), 32'd1);
    if (found) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge CLOCK);
        check({name, " digit"}, {20'h0, bus.DIG, bus.SEL}, {20'h0, digs[8*k +: 8], ~(4'b0001 << k)});
        repeat (15) @(negedge CLOCK);
      end
    end
  endtask

  task automatic duty(input string name, input logic [1:0] b, input int exp_lit);
    int lit = 0;
    load_on_boundary(16'h8888, 4'h0, b, 1'b0);
    @(negedge CLOCK);
    for (int i = 0; i < 64; i++) begin
      @(negedge CLOCK);
      if (bus.SEL != 4'hF) lit++;
    end
    check(name, 32'(lit), 32'(exp_lit));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 2000000", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] rd;
    RESET = 1'b0;
    bus.iData = '0; bus.iDot = '0; bus.iBright = '0; bus.iBlankLZ = 1'b0; bus.iLoad = 1'b0;
    cyc(5);
    check("reset pins", {18'h0, bus.DIG, bus.SEL, bus.oFrame, bus.oPending}, {18'h0, 8'hFF, 4'hF, 2'b00});
    RESET = 1'b1;
    cyc(1);
    @(negedge CLOCK);
    check("first SEL after release", 32'(bus.SEL), 32'hE);

    // Mid-frame load, shown from the next frame.
    cyc(1);
    load(16'h12A0, 4'b0001, 2'd3, 1'b0);
    expect_frame("hex 12A0", 32'hF9A48840);

    // Leading-zero blanking keeps the decimal point.
    wait_midframe();
    load(16'h0005, 4'b0100, 2'd3, 1'b1);
    expect_frame("lz 0005", 32'hFF7FFF92);

    // Latest of two mid-frame strobes wins.
    wait_midframe();
    load(16'h1111, 4'h0, 2'd3, 1'b0);
    check("pending after load", 32'(bus.oPending), 32'd1);
    cyc(5);
    load(16'h2222, 4'h0, 2'd3, 1'b0);
    check("pending after 2nd load", 32'(bus.oPending), 32'd1);
    expect_frame("pend 2222", 32'hA4A4A4A4);
    check("pending cleared", 32'(bus.oPending), 32'd0);

    // A strobe on the boundary edge is displayed in the starting frame.
    load_on_boundary(16'h3456, 4'h0, 2'd3, 1'b0);
    check("pending after bnd load", 32'(bus.oPending), 32'd0);
    expect_frame("bnd 3456", 32'hB0999282);

    duty("duty B0", 2'd0, 16);
    duty("duty B2", 2'd2, 48);
    duty("duty B3", 2'd3, 64);

    // Reset mid-digit discards pending data and clears the shadow.
    wait_midframe();
    load(16'h7777, 4'hF, 2'd3, 1'b0);
    cyc(3);
    RESET = 1'b0;
    #1;
    check("async reset pins", {18'h0, bus.DIG, bus.SEL, bus.oFrame, bus.oPending}, {18'h0, 8'hFF, 4'hF, 2'b00});
    cyc(4);
    RESET = 1'b1;
    expect_frame("after reset", 32'hC0C0C0C0);

    // Random loads, some on boundary edges, all checked by the scoreboard.
    cyc(1);
    for (int n = 0; n < 30; n++) begin
      rd = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
      if ($urandom_range(0, 4) == 0)
        load_on_boundary(rd, 4'($urandom), 2'($urandom), 1'($urandom));
      else
        load(rd, 4'($urandom), 2'($urandom), 1'($urandom));
      cyc($urandom_range(0, 100));
    end
    cyc(200);

    check("enough scoreboard comparisons", 32'(n_cmp > 1000), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
